mac_seq: RTL and testbench
==========================

Name: mac_seq

Overview:
- Sequencer that drives the MAC datapath.
- Holds two N_TAPS-deep operand banks (A and B), loaded through a simple write port.
- On start, streams operand pairs into the MAC with mac_en held high, pads with zero pairs while the MAC pipeline drains, then captures the MAC result and its tag.
- Sits between the host/register side and the MAC; owns mac_en, so it also owns the MAC's internal counter clearing.

Parameters:
- DW, 8, operand width of mac_a/mac_b and of bank entries
- N_TAPS, 8, number of operand pairs streamed per job
- AW, 3, bank address width and tag width; N_TAPS <= 2**AW
- DRAIN_CYC, 4, zero-padding cycles after the last pair, before capture

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low
- wr_en  in  1  bank write strobe
- wr_sel  in  1  0 = bank A, 1 = bank B
- wr_addr  in  AW  bank entry index
- wr_data  in  DW  entry value
- start  in  1  job start pulse
- start_tag  in  AW  tag sent to the MAC as addr
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse, result valid
- result  out  16  captured MAC output
- result_addr  out  AW  captured MAC out_addr
- mac_a  out  DW  operand A to the MAC
- mac_b  out  DW  operand B to the MAC
- mac_addr  out  AW  tag to the MAC
- mac_en  out  1  MAC enable
- mac_out  in  16  MAC result
- mac_out_addr  in  AW  MAC result tag

Behaviour:
- Reset (rst low, async): state IDLE; busy, done, mac_en = 0; mac_a, mac_b, mac_addr, result, result_addr = 0; all bank entries = 0; counters = 0.
- All outputs are registered.
- FSM states: IDLE, FEED, DRAIN, CAPT, DONE.
- IDLE:
  - mac_en = 0. This guarantees at least one low cycle between jobs, so the MAC counter clears.
  - Writes accepted.
  - start = 1 latches start_tag and goes to FEED.
- FEED: N_TAPS cycles; index k = 0..N_TAPS-1.
  - mac_en = 1, mac_a = A[k], mac_b = B[k], mac_addr = tag.
  - After k = N_TAPS-1, go to DRAIN.
- DRAIN: DRAIN_CYC cycles.
  - mac_en = 1, mac_a = mac_b = 0, mac_addr = tag.
  - Then go to CAPT.
- CAPT: one cycle.
  - mac_en = 1; result <= mac_out and result_addr <= mac_out_addr at the end of this cycle.
  - Go to DONE.
- DONE: one cycle.
  - done = 1, busy = 0, mac_en = 0, mac_a = mac_b = 0.
  - Return to IDLE.
- Timing (start sampled high at edge E0):
  - First pair is on mac_a/mac_b in cycle E0+1.
  - busy is high for cycles E0+1 through E0+N_TAPS+DRAIN_CYC+1.
  - done is high in cycle E0+N_TAPS+DRAIN_CYC+2, which is cycle 14 with defaults.
- Writes:
  - A write in IDLE commits at the edge where wr_en is sampled.
  - A write in the same cycle as start commits before FEED reads, so FEED uses the new value.
  - wr_en while busy or in DONE is ignored; banks are locked during a job.
  - wr_addr >= N_TAPS is ignored.
- start while busy or in DONE is ignored; no queuing.
- result and result_addr hold their value until the next CAPT or reset.
- Reset asserted mid-job: immediate return to IDLE with reset values; mac_en drops asynchronously; banks are cleared.
- No arithmetic in this block; bank values are passed through unmodified (unsigned DW bits).

Test Plan:
- Reset, then check outputs: all outputs 0, state IDLE, mac_en 0; read-back via a job shows mac_a = mac_b = 0 for all 8 FEED cycles.
- Load A = 1..8 and B = 2 at indices 0..7, then pulse start with tag 5:
  - mac_a = 1,2,...,8 and mac_b = 2 on cycles E0+1..E0+8, mac_addr = 5, mac_en = 1.
  - 4 zero cycles follow.
  - done on cycle E0+14.
- Stub mac_out = 16'h1234 and mac_out_addr = 5 during CAPT: result = 16'h1234, result_addr = 5 on the done cycle, held afterwards.
- During a job, write A[0] = 8'hFF and pulse start again: both ignored; the next job still streams the old A[0]; busy is unaffected.
- Write A[3] = 8'h7E in the same cycle as start: FEED cycle k = 3 drives mac_a = 8'h7E.
- Assert rst low during DRAIN: mac_en = 0 and busy = 0 asynchronously, no done pulse, result = 0; after release, a new job runs normally with banks read as 0.

Source files
------------

// File: rtl/mac_seq.sv
// mac_seq -- operand sequencer in front of the MAC datapath.
//
// Holds two N_TAPS-deep operand banks (A, B) written through a simple write
// port while idle. A start pulse streams A[k]/B[k] into the MAC with mac_en
// high, pads with zero pairs while the MAC pipeline drains, then captures
// the MAC result and its tag. mac_en is low in IDLE and DONE, so the MAC's
// internal accumulator is guaranteed to clear between jobs.
//
// Ports:
//   clk, rst          clock (rising edge), async active-low reset
//   wr_en/wr_sel      bank write strobe, bank select (0 = A, 1 = B)
//   wr_addr/wr_data   bank entry index and value
//   start/start_tag   job start pulse and tag forwarded as mac_addr
//   busy/done         job in progress / one-cycle result-valid pulse
//   result            captured mac_out
//   result_addr       captured mac_out_addr
//   mac_a/mac_b       operands to the MAC
//   mac_addr/mac_en   tag and enable to the MAC
//   mac_out           MAC result
//   mac_out_addr      MAC result tag
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | mac_en low, bank writes accepted, waiting for start
// FEED  | streaming A[k]/B[k], k = 0..N_TAPS-1
// DRAIN | zero pairs for DRAIN_CYC cycles while the MAC pipeline empties
// CAPT  | one cycle; mac_out/mac_out_addr captured at its end
// DONE  | one cycle; done pulse, mac_en low

module mac_seq #(
    parameter int DW        = 8,
    parameter int N_TAPS    = 8,
    parameter int AW        = 3,
    parameter int DRAIN_CYC = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [AW-1:0] start_tag,
    output logic          busy,
    output logic          done,
    output logic [15:0]   result,
    output logic [AW-1:0] result_addr,
    output logic [DW-1:0] mac_a,
    output logic [DW-1:0] mac_b,
    output logic [AW-1:0] mac_addr,
    output logic          mac_en,
    input  logic [15:0]   mac_out,
    input  logic [AW-1:0] mac_out_addr
);

    localparam int DCW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [AW-1:0]  K_LAST = AW'(N_TAPS - 1);
    localparam logic [DCW-1:0] D_LOAD = DCW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         nxt_state;
    logic [AW-1:0]  k;
    logic [DCW-1:0] dcnt;

    logic [DW-1:0]  bank_a [N_TAPS];
    logic [DW-1:0]  bank_b [N_TAPS];

    logic           wr_ok;
    logic [AW-1:0]  rd_idx;
    logic [DW-1:0]  rd_a;
    logic [DW-1:0]  rd_b;
    logic           nxt_active;

    // Index of the pair that will be on mac_a/mac_b in the next cycle.
    // A write landing in the start cycle is forwarded so FEED sees the new
    // value even for entry 0, which is read at that same edge.
    always_comb begin
        wr_ok  = wr_en && (state == S_IDLE) &&
                 ({1'b0, wr_addr} < (AW+1)'(N_TAPS));
        rd_idx = '0;
        if (state == S_FEED && k != K_LAST) begin
            rd_idx = k + AW'(1);
        end
        rd_a = bank_a[rd_idx];
        rd_b = bank_b[rd_idx];
        if (wr_ok && !wr_sel && wr_addr == rd_idx) begin
            rd_a = wr_data;
        end
        if (wr_ok && wr_sel && wr_addr == rd_idx) begin
            rd_b = wr_data;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            S_IDLE:  if (start) nxt_state = S_FEED;
            S_FEED:  if (k == K_LAST) nxt_state = S_DRAIN;
            S_DRAIN: if (dcnt == '0) nxt_state = S_CAPT;
            S_CAPT:  nxt_state = S_DONE;
            S_DONE:  nxt_state = S_IDLE;
            default: nxt_state = S_IDLE;
        endcase
        nxt_active = (nxt_state == S_FEED) || (nxt_state == S_DRAIN) ||
                     (nxt_state == S_CAPT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_TAPS; i++) begin
                bank_a[i] <= '0;
                bank_b[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_sel) begin
                bank_b[wr_addr] <= wr_data;
            end else begin
                bank_a[wr_addr] <= wr_data;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            k           <= '0;
            dcnt        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            mac_en      <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_addr    <= '0;
            result      <= '0;
            result_addr <= '0;
        end else begin
            state  <= nxt_state;
            busy   <= nxt_active;
            mac_en <= nxt_active;
            done   <= (nxt_state == S_DONE);
            mac_a  <= (nxt_state == S_FEED) ? rd_a : '0;
            mac_b  <= (nxt_state == S_FEED) ? rd_b : '0;

            if (state == S_IDLE && start) begin
                mac_addr <= start_tag;
            end

            if (nxt_state == S_FEED) begin
                k <= rd_idx;
            end

            if (state == S_FEED && nxt_state == S_DRAIN) begin
                dcnt <= D_LOAD;
            end else if (state == S_DRAIN && dcnt != '0) begin
                dcnt <= dcnt - DCW'(1);
            end

            if (state == S_CAPT) begin
                result      <= mac_out;
                result_addr <= mac_out_addr;
            end
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// Testbench for mac_seq: directed jobs checked against a job-timeline model
// (outputs derived from cycles elapsed since the accepted start) plus
// hand-computed literal expectations.

module tb_mac_seq;

    localparam int DW = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int D  = 4;
    localparam int T_CAPT = N + D + 1;
    localparam int T_DONE = N + D + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW-1:0] start_tag = '0;
    logic          busy;
    logic          done;
    logic [15:0]   result;
    logic [AW-1:0] result_addr;
    logic [DW-1:0] mac_a;
    logic [DW-1:0] mac_b;
    logic [AW-1:0] mac_addr;
    logic          mac_en;
    logic [15:0]   mac_out = '0;
    logic [AW-1:0] mac_out_addr = '0;

    mac_seq #(.DW(DW), .N_TAPS(N), .AW(AW), .DRAIN_CYC(D)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_tag(start_tag),
        .busy(busy), .done(done), .result(result), .result_addr(result_addr),
        .mac_a(mac_a), .mac_b(mac_b), .mac_addr(mac_addr), .mac_en(mac_en),
        .mac_out(mac_out), .mac_out_addr(mac_out_addr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_cyc = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: timed out at %0t", nm, $time);
    endtask

    // Model: m_off = cycles since the edge that accepted start (-1 = idle).
    int            m_off = -1;
    logic [DW-1:0] m_a [N] = '{default: '0};
    logic [DW-1:0] m_b [N] = '{default: '0};
    logic [DW-1:0] s_a [N] = '{default: '0};
    logic [DW-1:0] s_b [N] = '{default: '0};
    logic [AW-1:0] m_tag = '0;
    logic [15:0]   m_res = '0;
    logic [AW-1:0] m_res_addr = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_off = -1;
            for (int i = 0; i < N; i++) begin
                m_a[i] = '0;
                m_b[i] = '0;
            end
            m_res = '0;
            m_res_addr = '0;
        end else if (m_off < 0) begin
            if (wr_en && int'(wr_addr) < N) begin
                if (wr_sel) m_b[wr_addr] = wr_data;
                else        m_a[wr_addr] = wr_data;
            end
            if (start) begin
                s_a = m_a;
                s_b = m_b;
                m_tag = start_tag;
                m_off = 1;
            end
        end else begin
            if (m_off == T_CAPT) begin
                m_res = mac_out;
                m_res_addr = mac_out_addr;
            end
            m_off = (m_off == T_DONE) ? -1 : m_off + 1;
        end
    end

    always @(posedge clk) n_cyc++;

    // MAC stub: a distinct value every cycle, the job's stub value only in CAPT.
    logic [15:0]   stub_out = '0;
    logic [AW-1:0] stub_addr = '0;
    always @(negedge clk) begin
        if (m_off == T_CAPT) begin
            mac_out = stub_out;
            mac_out_addr = stub_addr;
        end else begin
            mac_out = 16'hBAD0 ^ 16'(n_cyc);
            mac_out_addr = AW'(n_cyc);
        end
    end

    always @(negedge clk) begin
        if (rst && chk_on) begin
            chk("busy", 32'(busy), 32'(m_off >= 1 && m_off <= T_CAPT));
            chk("mac_en", 32'(mac_en), 32'(m_off >= 1 && m_off <= T_CAPT));
            chk("done", 32'(done), 32'(m_off == T_DONE));
            if (m_off >= 1) begin
                chk("mac_a", 32'(mac_a), (m_off <= N) ? 32'(s_a[m_off-1]) : 32'd0);
                chk("mac_b", 32'(mac_b), (m_off <= N) ? 32'(s_b[m_off-1]) : 32'd0);
            end
            if (m_off >= 1 && m_off <= T_CAPT) begin
                chk("mac_addr", 32'(mac_addr), 32'(m_tag));
            end
            chk("result", 32'(result), 32'(m_res));
            chk("result_addr", 32'(result_addr), 32'(m_res_addr));
        end
    end

    task automatic pulse_start(input logic [AW-1:0] tag);
        start = 1'b1;
        start_tag = tag;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wr(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic wait_off(input int target, input string nm);
        for (int i = 0; i < 60 && m_off != target; i++) @(negedge clk);
        if (m_off != target) timeout(nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_mac_a", 32'(mac_a), 32'd0);
        chk("rst_mac_b", 32'(mac_b), 32'd0);
        chk("rst_mac_addr", 32'(mac_addr), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_result_addr", 32'(result_addr), 32'd0);
        rst = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Job 0: empty banks read back as zero.
        stub_out = 16'h0001; stub_addr = 3'd2;
        pulse_start(3'd2);
        chk("j0_en_k0", 32'(mac_en), 32'd1);
        chk("j0_a_k0", 32'(mac_a), 32'd0);
        wait_off(-1, "j0_idle");
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            wr(1'b0, AW'(i), DW'(i + 1));
            wr(1'b1, AW'(i), 8'd2);
        end

        // Job 1: A = 1..8, B = 2, tag 5, MAC returns 1234/5.
        stub_out = 16'h1234; stub_addr = 3'd5;
        pulse_start(3'd5);
        chk("j1_a_k0", 32'(mac_a), 32'd1);
        chk("j1_b_k0", 32'(mac_b), 32'd2);
        chk("j1_tag", 32'(mac_addr), 32'd5);
        repeat (2) @(negedge clk);
        chk("j1_a_k2", 32'(mac_a), 32'd3);
        repeat (5) @(negedge clk);
        chk("j1_a_k7", 32'(mac_a), 32'd8);
        @(negedge clk);
        chk("j1_drain_a", 32'(mac_a), 32'd0);
        repeat (4) @(negedge clk);
        chk("j1_done_e13", 32'(done), 32'd0);
        chk("j1_busy_e13", 32'(busy), 32'd1);
        @(negedge clk);
        chk("j1_done_e14", 32'(done), 32'd1);
        chk("j1_busy_e14", 32'(busy), 32'd0);
        chk("j1_result", 32'(result), 32'h1234);
        chk("j1_result_addr", 32'(result_addr), 32'd5);
        repeat (2) @(negedge clk);
        chk("j1_result_held", 32'(result), 32'h1234);
        chk("j1_done_e16", 32'(done), 32'd0);

        // Job 2: write and start during the job are ignored.
        stub_out = 16'hA5A5; stub_addr = 3'd1;
        pulse_start(3'd1);
        repeat (3) @(negedge clk);
        wr(1'b0, 3'd0, 8'hFF);
        pulse_start(3'd7);
        chk("j2_busy_mid", 32'(busy), 32'd1);
        chk("j2_tag_kept", 32'(mac_addr), 32'd1);
        wait_off(T_DONE, "j2_done");
        // Write and start in the DONE cycle are ignored as well.
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd1; wr_data = 8'hAA;
        start = 1'b1; start_tag = 3'd4;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        chk("j2_no_restart", 32'(busy), 32'd0);
        @(negedge clk);

        // Job 3: old A[0] and A[1] still in the bank.
        stub_out = 16'h5A5A; stub_addr = 3'd3;
        pulse_start(3'd3);
        chk("j3_a0_old", 32'(mac_a), 32'd1);
        @(negedge clk);
        chk("j3_a1_old", 32'(mac_a), 32'd2);
        wait_off(-1, "j3_idle");
        @(negedge clk);

        // Job 4: write A[3] in the start cycle.
        stub_out = 16'hC0DE; stub_addr = 3'd6;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 3'd3; wr_data = 8'h7E;
        start = 1'b1; start_tag = 3'd6;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("j4_a3_new", 32'(mac_a), 32'h7E);
        wait_off(-1, "j4_idle");
        @(negedge clk);

        // Job 5: write B[0] in the start cycle, then reset during DRAIN.
        stub_out = 16'hBEEF; stub_addr = 3'd0;
        wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 3'd0; wr_data = 8'h3C;
        start = 1'b1; start_tag = 3'd0;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        chk("j5_b0_new", 32'(mac_b), 32'h3C);
        wait_off(10, "j5_drain");
        #2 rst = 1'b0;
        #1;
        chk("arst_mac_en", 32'(mac_en), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("arst_no_done", 32'(done), 32'd0);

        // Job 6: banks cleared by reset.
        stub_out = 16'h0F0F; stub_addr = 3'd6;
        pulse_start(3'd6);
        chk("j6_a0_cleared", 32'(mac_a), 32'd0);
        chk("j6_b0_cleared", 32'(mac_b), 32'd0);
        wait_off(-1, "j6_idle");
        chk("j6_result", 32'(result), 32'h0F0F);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
